// File: rtl/regfile_ser_loader_pkg.sv
// Shared definitions for the serial loader: FSM state encodings and
// default parameter values. Optional even-parity checking is enabled by
// defining PARITY_CHK_EN at compile time.
package regfile_ser_loader_pkg;

  // Default geometry; BITWIDTH must match the downstream register stage.
  localparam int LDR_BITWIDTH_DEF = 11;
  localparam int LDR_CNT_W_DEF    = 4;
  localparam int LDR_TIMEOUT_DEF  = 16;
  localparam int LDR_TO_W_DEF     = 5;

  // Loader FSM states. PARITY is only reachable when PARITY_CHK_EN is defined.
  typedef enum logic [1:0] {
    LDR_IDLE   = 2'b00,
    LDR_SHIFT  = 2'b01,
    LDR_PARITY = 2'b10,
    LDR_COMMIT = 2'b11
  } ldr_state_e;

endpackage

// File: rtl/ldr_gap_timer.sv
// Inter-bit gap counter. Counts consecutive stall cycles inside a frame and
// flags the cycle in which the count would reach TIMEOUT.
module ldr_gap_timer #(
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TO_W-1:0] gap_q;
  logic [TO_W-1:0] gap_d;

  // Next gap count: clear wins over increment.
  always_comb begin
    gap_d = gap_q;
    if (clr) begin
      gap_d = '0;
    end else if (inc) begin
      gap_d = gap_q + TO_W'(1);
    end
  end

  // Expiry is the stall cycle that would bring the count to TIMEOUT.
  assign expired = inc && !clr && (gap_q == TO_W'(TIMEOUT - 1));

  // Gap counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

endmodule

// File: rtl/regfile_ser_loader.sv
// Serial-to-parallel loader: assembles an MSB-first frame into a BITWIDTH
// word and writes it to the downstream register with a one-cycle strobe.
// Frames abort on an inter-bit gap timeout. Define PARITY_CHK_EN to append
// and check an even-parity bit after the data bits.
//
// Input qualifier: a serial bit is consumed on every rising edge where
// ser_valid=1 and the FSM is collecting (SHIFT/PARITY) with start=0; there
// is no back-pressure, ser_valid=0 is a source stall that advances the gap
// timer. All outputs are registered.
module regfile_ser_loader
  import regfile_ser_loader_pkg::*;
#(
  parameter int BITWIDTH = LDR_BITWIDTH_DEF,
  parameter int CNT_W    = LDR_CNT_W_DEF,
  parameter int TIMEOUT  = LDR_TIMEOUT_DEF,
  parameter int TO_W     = LDR_TO_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                ser_in,
  input  logic                ser_valid,
  output logic                busy,
  output logic [BITWIDTH-1:0] d_out,
  output logic                wr_en,
  output logic                frame_err
);

  ldr_state_e          state_q, state_d;
  logic [BITWIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BITWIDTH-1:0] d_out_q, d_out_d;
  logic                wr_en_q, wr_en_d;
  logic                frame_err_q, frame_err_d;
  logic                busy_q, busy_d;

  logic                in_frame;
  logic                last_bit;
  logic                gap_clr;
  logic                gap_inc;
  logic                gap_expired;
`ifdef PARITY_CHK_EN
  logic                parity_ok;
`endif

  // Frame collection status and gap-timer controls.
  always_comb begin
    in_frame = (state_q == LDR_SHIFT) || (state_q == LDR_PARITY);
    last_bit = (cnt_q == CNT_W'(BITWIDTH - 1));
    gap_inc  = in_frame && !start && !ser_valid;
    gap_clr  = !in_frame || start || ser_valid;
`ifdef PARITY_CHK_EN
    parity_ok = ~^{sh_q, ser_in};
`endif
  end

  ldr_gap_timer #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_gap_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (gap_clr),
    .inc     (gap_inc),
    .expired (gap_expired)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LDR_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; start restarts any frame except one already committing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LDR_IDLE: begin
        if (start) state_d = LDR_SHIFT;
      end
      LDR_SHIFT: begin
        if (start) begin
          state_d = LDR_SHIFT;
        end else if (ser_valid && last_bit) begin
`ifdef PARITY_CHK_EN
          state_d = LDR_PARITY;
`else
          state_d = LDR_COMMIT;
`endif
        end else if (gap_expired) begin
          state_d = LDR_IDLE;
        end
      end
`ifdef PARITY_CHK_EN
      LDR_PARITY: begin
        if (start) begin
          state_d = LDR_SHIFT;
        end else if (ser_valid) begin
          state_d = parity_ok ? LDR_COMMIT : LDR_IDLE;
        end else if (gap_expired) begin
          state_d = LDR_IDLE;
        end
      end
`endif
      LDR_COMMIT: state_d = LDR_IDLE;
      default:    state_d = LDR_IDLE;
    endcase
  end

  // Registered outputs: strobe/data on commit, error pulse on timeout or bad parity.
  always_comb begin
    d_out_d     = d_out_q;
    wr_en_d     = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_q != LDR_IDLE);
    if (state_q == LDR_COMMIT) begin
      d_out_d = sh_q;
      wr_en_d = 1'b1;
    end
    if (gap_expired) begin
      frame_err_d = 1'b1;
    end
`ifdef PARITY_CHK_EN
    if ((state_q == LDR_PARITY) && !start && ser_valid && !parity_ok) begin
      frame_err_d = 1'b1;
    end
`endif
  end

  // Shift register and bit counter: cleared on a (re)start, advanced per data bit.
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (start && (state_q != LDR_COMMIT)) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if ((state_q == LDR_SHIFT) && ser_valid) begin
      sh_d  = {sh_q[BITWIDTH-2:0], ser_in};
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q        <= '0;
      cnt_q       <= '0;
      d_out_q     <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      d_out_q     <= d_out_d;
      wr_en_q     <= wr_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign busy      = busy_q;
  assign d_out     = d_out_q;
  assign wr_en     = wr_en_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_regfile_ser_loader.sv
// Self-checking bench for regfile_ser_loader: directed scenarios followed by
// randomized frames (normal, timeout, restart, bad parity) scored against a
// frame-level expectation queue. Honours PARITY_CHK_EN like the design.
module tb_regfile_ser_loader;
  import regfile_ser_loader_pkg::*;

  localparam int BW      = LDR_BITWIDTH_DEF;
  localparam int TIMEOUT = LDR_TIMEOUT_DEF;
`ifdef PARITY_CHK_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = BW + PAR;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          ser_in;
  logic          ser_valid;
  logic          busy;
  logic [BW-1:0] d_out;
  logic          wr_en;
  logic          frame_err;

  int test_cnt = 0;
  int fail_cnt = 0;
  int wr_cnt   = 0;
  int err_cnt  = 0;
  int push_cnt = 0;
  int exp_err  = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] prev_d;

  regfile_ser_loader #(
    .BITWIDTH (BW),
    .CNT_W    (LDR_CNT_W_DEF),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (LDR_TO_W_DEF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .busy      (busy),
    .d_out     (d_out),
    .wr_en     (wr_en),
    .frame_err (frame_err)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must carry the oldest expected word; d_out holds otherwise.
  always @(negedge clk) begin
    if (rst) begin
      prev_d = '0;
    end else begin
      if (wr_en || frame_err) check("wr_err_exclusive", {31'b0, wr_en & frame_err}, 32'd0);
      if (frame_err) err_cnt++;
      if (wr_en) begin
        wr_cnt++;
        check("exp_q_nonempty", {31'b0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) check("wr_data", d_out, exp_q.pop_front());
      end else begin
        check("d_out_hold", d_out, prev_d);
      end
      prev_d = d_out;
    end
  end

  // Drivers: inputs change 1 time unit after the rising edge.
  task automatic step(input logic s, input logic v, input logic b);
    start = s; ser_valid = v; ser_in = b;
    @(posedge clk);
    #1;
  endtask

  task automatic low(input int n);
    repeat (n) step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  // Idle cycles with noise on the serial pins, which must be ignored.
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic do_start();
    step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  // Serial frame for a word: data MSB first, then (if enabled) the parity bit.
  function automatic logic [BW:0] frame_of(input logic [BW-1:0] w, input bit good);
`ifdef PARITY_CHK_EN
    return {w, good ? ^w : ~^w};
`else
    if (good) return {1'b0, w};
    return {1'b0, w};
`endif
  endfunction

  // Send the first n frame bits, with gmin..gmax stall cycles between bits.
  task automatic send_seq(input logic [BW:0] sv, input int n, input int gmin, input int gmax);
    for (int i = 0; i < n; i++) begin
      if (i > 0) low($urandom_range(gmin, gmax));
      step(1'b0, 1'b1, sv[FLEN-1-i]);
    end
  endtask

  task automatic expect_word(input logic [BW-1:0] w);
    exp_q.push_back(w);
    push_cnt++;
  endtask

  initial begin
    int e0;
    int w0;
    int kind;
    int k;
    int gmax;
    logic [BW-1:0] w;
    logic [BW-1:0] w2;

    rst = 1'b1; start = 1'b0; ser_valid = 1'b0; ser_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_d_out", d_out, 32'd0);
    check("rst_wr_en", {31'b0, wr_en}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_frame_err", {31'b0, frame_err}, 32'd0);
    rst = 1'b0;
    idle(3);

    // 1: back-to-back frame; strobe one clock after the last bit
    step(1'b1, 1'b1, 1'b1);
    expect_word(11'h5A3);
    send_seq(frame_of(11'h5A3, 1'b1), FLEN, 0, 0);
    check("t1_wr_early", {31'b0, wr_en}, 32'd0);
    check("t1_busy_mid", {31'b0, busy}, 32'd1);
    step(1'b0, 1'b0, 1'b0);
    check("t1_wr_en", {31'b0, wr_en}, 32'd1);
    check("t1_d_out", d_out, 32'h5A3);
    step(1'b0, 1'b0, 1'b0);
    check("t1_wr_after", {31'b0, wr_en}, 32'd0);
    check("t1_busy_low", {31'b0, busy}, 32'd0);

    // 2: same frame with 3 stall cycles between bits
    e0 = err_cnt; w0 = wr_cnt;
    expect_word(11'h5A3);
    do_start();
    send_seq(frame_of(11'h5A3, 1'b1), FLEN, 3, 3);
    idle(3);
    check("t2_wr_count", wr_cnt - w0, 32'd1);
    check("t2_no_err", err_cnt - e0, 32'd0);

    // 3: 5 bits then a 16-cycle stall -> one error pulse, no write
    w0 = wr_cnt;
    do_start();
    send_seq(frame_of(11'h0F0, 1'b1), 5, 0, 0);
    low(TIMEOUT - 1);
    check("t3_err_early", {31'b0, frame_err}, 32'd0);
    low(1);
    check("t3_err_pulse", {31'b0, frame_err}, 32'd1);
    exp_err++;
    low(1);
    check("t3_err_once", {31'b0, frame_err}, 32'd0);
    low(1);
    check("t3_busy_low", {31'b0, busy}, 32'd0);
    check("t3_d_out", d_out, 32'h5A3);
    check("t3_no_wr", wr_cnt - w0, 32'd0);

    // 4: restart after 6 bits, then 11'h7FF (bit presented with start is dropped)
    e0 = err_cnt; w0 = wr_cnt;
    do_start();
    send_seq(frame_of(11'h2C4, 1'b1), 6, 0, 1);
    step(1'b1, 1'b1, 1'b0);
    expect_word(11'h7FF);
    send_seq(frame_of(11'h7FF, 1'b1), FLEN, 0, 0);
    idle(2);
    check("t4_wr_count", wr_cnt - w0, 32'd1);
    check("t4_no_err", err_cnt - e0, 32'd0);
    check("t4_d_out", d_out, 32'h7FF);

    // Maximum tolerated gap before each bit, and start ignored while committing
    e0 = err_cnt;
    expect_word(11'h2B5);
    do_start();
    send_seq(frame_of(11'h2B5, 1'b1), FLEN, TIMEOUT - 1, TIMEOUT - 1);
    step(1'b1, 1'b0, 1'b0);
    check("gap15_wr_en", {31'b0, wr_en}, 32'd1);
    check("gap15_d_out", d_out, 32'h2B5);
    check("gap15_no_err", err_cnt - e0, 32'd0);
    step(1'b0, 1'b0, 1'b0);
    check("commit_start_ignored", {31'b0, busy}, 32'd0);
    idle(2);

    // 5: async reset after 8 bits, then frame 11'h001
    do_start();
    send_seq(frame_of(11'h3FF, 1'b1), 8, 0, 0);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_d_out", d_out, 32'd0);
    check("t5_rst_busy", {31'b0, busy}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    expect_word(11'h001);
    do_start();
    send_seq(frame_of(11'h001, 1'b1), FLEN, 0, 2);
    check("t5_d_out_pre", d_out, 32'd0);
    idle(2);
    check("t5_d_out", d_out, 32'h001);

`ifdef PARITY_CHK_EN
    // 6: parity bit wrong, then right
    w0 = wr_cnt;
    do_start();
    send_seq({11'h001, 1'b0}, FLEN, 0, 0);
    check("t6_bad_err", {31'b0, frame_err}, 32'd1);
    check("t6_bad_no_wr", {31'b0, wr_en}, 32'd0);
    exp_err++;
    idle(2);
    expect_word(11'h001);
    do_start();
    send_seq({11'h001, 1'b1}, FLEN, 0, 0);
    idle(2);
    check("t6_good_wr", wr_cnt - w0, 32'd1);
    check("t6_good_d_out", d_out, 32'h001);
`endif

    // Randomized frames
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 9);
      w    = BW'($urandom);
      gmax = ($urandom_range(0, 3) == 0) ? TIMEOUT - 1 : 2;
      do_start();
      if (kind == 0) begin
        k = $urandom_range(0, FLEN - 1);
        send_seq(frame_of(w, 1'b1), k, 0, gmax);
        low(TIMEOUT);
        exp_err++;
      end else if (kind == 1) begin
        k = $urandom_range(0, FLEN - 1);
        send_seq(frame_of(w, 1'b1), k, 0, gmax);
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        w2 = BW'($urandom);
        expect_word(w2);
        send_seq(frame_of(w2, 1'b1), FLEN, 0, gmax);
      end else if (kind == 2 && PAR == 1) begin
        send_seq(frame_of(w, 1'b0), FLEN, 0, gmax);
        exp_err++;
      end else begin
        expect_word(w);
        send_seq(frame_of(w, 1'b1), FLEN, 0, gmax);
      end
      idle($urandom_range(1, 3));
    end
    idle(3);

    check("total_writes", wr_cnt, push_cnt);
    check("total_errors", err_cnt, exp_err);
    check("exp_q_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
